// File: rtl/clock_pkg.sv
// Shared types and constants for the front-panel clock-setting sequencer:
// FSM state encoding, field-select codes and BCD field limits.
package clock_pkg;

  typedef enum logic [2:0] {
    RUN,
    EDIT_H,
    COMMIT_H,
    EDIT_M,
    COMMIT_M,
    EDIT_S,
    COMMIT_S
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_HOUR = 2'b01,
    SEL_MIN  = 2'b10,
    SEL_SEC  = 2'b11
  } sel_e;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

endpackage

// File: rtl/button_debounce.sv
// One push-button front end: two-flop synchroniser, stability counter and a
// single-cycle pulse on each accepted 0->1 transition of the debounced level.
module button_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  logic        sync1_q, sync2_q;
  logic        stable_q, stable_d;
  logic        press_q, press_d;
  logic [15:0] cnt_q, cnt_d;

  // Bring the raw pin into the clk domain.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it differs from the stable one for DEBOUNCE_CYCLES samples.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d    = 16'd0;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= 16'd0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/clock_set_controller.sv
// Front-panel sequencer for ClockAndSet: walks hour -> minute -> second
// editing from three buttons and issues select/value/confirm load strobes.
// Optional build macro EDIT_TIMEOUT_EN abandons an idle edit after
// TIMEOUT_CYCLES; without it TIMEOUT_CYCLES is unused.
module clock_set_controller
  import clock_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  CONFIRM_CYCLES  = 8'd4,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd50000000
) (
  input  logic       clk,
  input  logic       cr,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [7:0] hour_in,
  input  logic [7:0] minute_in,
  input  logic [7:0] second_in,
  output logic [1:0] clock_set_select,
  output logic       set_confirm,
  output logic [7:0] set_value,
  output logic [2:0] blink,
  output logic       editing
);

  logic   p_mode, p_inc, p_dec;
  state_e state_q, state_d;
  logic [7:0] edit_q, edit_d;
  logic [7:0] conf_cnt_q, conf_cnt_d;
`ifdef EDIT_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
`endif

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst(cr), .btn_i(btn_mode), .press_o(p_mode)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(clk), .rst(cr), .btn_i(btn_inc), .press_o(p_inc)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .clk(clk), .rst(cr), .btn_i(btn_dec), .press_o(p_dec)
  );

  // BCD step with wrap; anything non-BCD or above the field limit snaps to 00.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] max_v,
                                          input logic up);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = v[7:4];
    lo = v[3:0];
    if (hi > 4'd9 || lo > 4'd9 || v > max_v) return 8'h00;
    if (up) begin
      if (v == max_v) return 8'h00;
      if (lo == 4'd9) return {hi + 4'd1, 4'd0};
      return {hi, lo + 4'd1};
    end
    if (v == 8'h00) return max_v;
    if (lo == 4'd0) return {hi - 4'd1, 4'd9};
    return {hi, lo - 4'd1};
  endfunction

  // Next-state, edit register and Moore outputs.
  always_comb begin
    state_d          = state_q;
    edit_d           = edit_q;
    conf_cnt_d       = 8'd0;
`ifdef EDIT_TIMEOUT_EN
    idle_d           = 32'd0;
`endif
    clock_set_select = SEL_NONE;
    set_confirm      = 1'b0;
    set_value        = 8'h00;
    blink            = 3'b000;
    editing          = 1'b0;

    case (state_q)
      RUN: begin
        if (p_mode) begin
          state_d = EDIT_H;
          edit_d  = hour_in;
        end
      end

      EDIT_H, EDIT_M, EDIT_S: begin
        editing   = 1'b1;
        set_value = edit_q;
        blink     = (state_q == EDIT_H) ? 3'b100 :
                    (state_q == EDIT_M) ? 3'b010 : 3'b001;
        if (p_mode) begin
          state_d = (state_q == EDIT_H) ? COMMIT_H :
                    (state_q == EDIT_M) ? COMMIT_M : COMMIT_S;
        end else if (p_inc ^ p_dec) begin
          edit_d = bcd_step(edit_q, (state_q == EDIT_H) ? HOUR_MAX : MINSEC_MAX, p_inc);
        end
`ifdef EDIT_TIMEOUT_EN
        if (!(p_mode || p_inc || p_dec)) begin
          if (idle_q == TIMEOUT_CYCLES - 32'd1) state_d = RUN;
          else                                  idle_d  = idle_q + 32'd1;
        end
`endif
      end

      COMMIT_H, COMMIT_M, COMMIT_S: begin
        editing     = 1'b1;
        set_value   = edit_q;
        set_confirm = 1'b1;
        clock_set_select = (state_q == COMMIT_H) ? SEL_HOUR :
                           (state_q == COMMIT_M) ? SEL_MIN  : SEL_SEC;
        blink       = (state_q == COMMIT_H) ? 3'b100 :
                      (state_q == COMMIT_M) ? 3'b010 : 3'b001;
        if (conf_cnt_q == CONFIRM_CYCLES - 8'd1) begin
          case (state_q)
            COMMIT_H: begin state_d = EDIT_M; edit_d = minute_in; end
            COMMIT_M: begin state_d = EDIT_S; edit_d = second_in; end
            default:  state_d = RUN;
          endcase
        end else begin
          conf_cnt_d = conf_cnt_q + 8'd1;
        end
      end

      default: state_d = RUN;
    endcase
  end

  // State, edit value and pulse-width counter registers.
  always_ff @(posedge clk or posedge cr) begin
    if (cr) begin
      state_q    <= RUN;
      edit_q     <= 8'h00;
      conf_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      edit_q     <= edit_d;
      conf_cnt_q <= conf_cnt_d;
    end
  end

`ifdef EDIT_TIMEOUT_EN
  // Idle counter for abandoning an untouched edit.
  always_ff @(posedge clk or posedge cr) begin
    if (cr) idle_q <= 32'd0;
    else    idle_q <= idle_d;
  end
`endif

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
Front-panel sequencer for the ClockAndSet timekeeping datapath.
- Turns three raw push-buttons (mode/inc/dec) into the clock_set_select / set_confirm / set_value protocol that loads hour, minute and second.
- Walks the user through hour -> minute -> second editing and provides a blink mask for the display driver.
- Sits between the board button pins and ClockAndSet, and reads back the live BCD time.

Parameters:
DEBOUNCE_CYCLES, 16'd50000, clk cycles a synchronised button level must be stable before it is accepted
CONFIRM_CYCLES, 8'd4, width in clk cycles of each set_confirm pulse
TIMEOUT_CYCLES, 32'd50000000, idle cycles before an edit is abandoned (used only with EDIT_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all logic on rising edge
cr  input  1  asynchronous active-high reset
btn_mode  input  1  raw mode button, active-high, asynchronous to clk
btn_inc  input  1  raw increment button, active-high, asynchronous
btn_dec  input  1  raw decrement button, active-high, asynchronous
hour_in  input  8  live BCD hour from ClockAndSet
minute_in  input  8  live BCD minute
second_in  input  8  live BCD second
clock_set_select  output  2  field select: 00 none, 01 hour, 10 minute, 11 second
set_confirm  output  1  load strobe to ClockAndSet, CONFIRM_CYCLES wide
set_value  output  8  BCD value to load into the selected field
blink  output  3  display blink mask {hour,minute,second}; one-hot while editing
editing  output  1  high in any EDIT_* or COMMIT_* state

Behaviour:
- Reset (cr=1, async):
  - state=RUN; clock_set_select=00, set_confirm=0, set_value=8'h00, blink=000, editing=0.
  - Debounce counters clear; stable levels clear to 0.
  - Reset mid-commit drops set_confirm in the same instant.
- Button path, per button:
  - 2-FF synchroniser, then debounce counter; the stable level updates after DEBOUNCE_CYCLES consecutive equal samples.
  - A 0->1 stable transition gives a one-cycle press pulse (p_mode/p_inc/p_dec).
  - Total latency from a clean raw edge to the pulse: 2 + DEBOUNCE_CYCLES + 1 cycles.
- FSM states: RUN, EDIT_H, COMMIT_H, EDIT_M, COMMIT_M, EDIT_S, COMMIT_S.
- RUN:
  - Outputs idle; inc/dec ignored.
  - p_mode -> EDIT_H; edit_reg <= hour_in, captured the same cycle.
- EDIT_x:
  - blink one-hot for the field (H=100, M=010, S=001); set_value=edit_reg; clock_set_select=00.
  - p_inc: BCD increment with wrap; hour 23->00, minute/second 59->00.
  - p_dec: BCD decrement with wrap; hour 00->23, minute/second 00->59.
  - p_inc and p_dec in the same cycle: both ignored.
  - p_mode -> COMMIT_x. p_mode wins over a simultaneous inc/dec, which is dropped.
- COMMIT_x:
  - clock_set_select = field code; set_value = edit_reg; set_confirm=1 for exactly CONFIRM_CYCLES cycles. Select and value are stable for the whole pulse.
  - All presses are ignored.
  - On completion, COMMIT_H -> EDIT_M capturing minute_in, COMMIT_M -> EDIT_S capturing second_in, COMMIT_S -> RUN.
  - Select returns to 00 on the first cycle after set_confirm falls.
- Arithmetic:
  - edit_reg holds 8-bit BCD: upper nibble tens, lower nibble units.
  - Units carry at 9; a non-BCD live input is loaded as-is and the next inc/dec forces it to 00.

Optional Feature:
EDIT_TIMEOUT_EN
- Defined: an idle counter runs in EDIT_* states and clears on any press pulse. When it reaches TIMEOUT_CYCLES, the FSM goes to RUN with no commit; fields already committed stay committed.
- Undefined: no counter; EDIT states are held indefinitely. The TIMEOUT_CYCLES parameter is present but unused.

Decomposition:
- Shared package clock_pkg:
  - state enum;
  - field-select codes SEL_NONE/SEL_HOUR/SEL_MIN/SEL_SEC;
  - BCD limit constants HOUR_MAX=8'h23, MINSEC_MAX=8'h59.
- One sub-module, button_debounce (synchroniser + counter + edge pulse), instantiated three times.
- The FSM and the BCD inc/dec logic stay in clock_set_controller.

Test Plan:
Use DEBOUNCE_CYCLES=4 and CONFIRM_CYCLES=3 for all scenarios.
1. Reset with cr=1 mid-run -> all outputs 0 and state RUN; a 2-cycle raw glitch on btn_mode produces no press.
2. hour_in=8'h22, press mode, inc x2 -> set_value 8'h23 then 8'h00; blink=100.
3. minute_in=8'h00, in EDIT_M press dec -> 8'h59. second_in=8'h59, in EDIT_S press inc -> 8'h00.
4. Press mode in EDIT_H with edit_reg=8'h07 -> select=01, set_value=07, set_confirm high exactly 3 cycles, then EDIT_M with edit_reg=minute_in.
5. Same-cycle inc+dec pulses -> no change. Same-cycle mode+inc -> commit of the un-incremented value. inc pressed during COMMIT -> ignored.
6. With EDIT_TIMEOUT_EN and TIMEOUT_CYCLES=20: idle in EDIT_M -> RUN after 20 cycles, no set_confirm. Assert cr during COMMIT_S -> set_confirm falls immediately.
